// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult_pkg
//  Purpose  : Shared types and constants for the sequential shift-add
//             multiplier: FSM state encoding, legal operand-width range
//             and the iteration-counter width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

    localparam int W_MIN = 2;
    localparam int W_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2. The counter holds W-1 down to 0, so clog2(W) bits suffice
    // for every legal W (W >= 2).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage : seq_mult_pkg
`default_nettype wire

// File: rtl/seq_mult_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult_addsub
//  Purpose  : Combinational (W+1)-bit adder/subtractor used as the partial
//             product accumulator of seq_mult.
//  Ports    : x   - (W+1)-bit accumulator input
//             y   - (W+1)-bit extended multiplicand (or zero)
//             sub - 1 selects s = x - y, 0 selects s = x + y
//             s   - (W+1)-bit result, wraps modulo 2^(W+1)
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mult_addsub #(
    parameter int W = 4
) (
    input  logic [W:0] x,
    input  logic [W:0] y,
    input  logic       sub,
    output logic [W:0] s
);

    always_comb begin
        s = sub ? (x - y) : (x + y);
    end

endmodule : seq_mult_addsub
`default_nettype wire

// File: rtl/seq_mult.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult
//  Purpose  : W x W sequential shift-add multiplier, 2W-bit product after
//             W iteration cycles, start/done handshake. One result per
//             W+2 cycles.
//  Ports    : clk         - rising-edge clock
//             rst         - synchronous active-high reset
//             start       - request a multiply (sampled in IDLE only)
//             a, b        - multiplicand / multiplier, captured on start
//             signed_mode - two's-complement operands (SEQ_MULT_SIGNED_EN)
//             busy        - high while iterating
//             done        - one-cycle pulse when p becomes valid
//             p           - product, held until next accepted start
//  Config   : define SEQ_MULT_SIGNED_EN to build signed_mode support
//             (sign-extended add, final-iteration subtract, arithmetic
//             shift). Without it the unit is unsigned, add-only.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic           signed_mode,
`endif
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int c_cnt_w = clog2(W);

    if (W < W_MIN || W > W_MAX) begin : g_bad_width
        $error("seq_mult: W out of supported range");
    end

    state_t             r_state;
    logic [W-1:0]       r_mcand;
    logic [W:0]         r_hi;
    logic [W-1:0]       r_lo;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sgn;

    logic               w_sgn_in;
    logic               w_last;
    logic [W:0]         w_ext;
    logic [W:0]         w_y;
    logic               w_sub;
    logic [W:0]         w_sum;
    logic               w_fill;
    logic [W:0]         w_hi_nx;
    logic [W-1:0]       w_lo_nx;

`ifdef SEQ_MULT_SIGNED_EN
    assign w_sgn_in = signed_mode;
`else
    assign w_sgn_in = 1'b0;
`endif

    assign w_last = (r_cnt == '0);

    always_comb begin
        w_ext = r_sgn ? {r_mcand[W-1], r_mcand} : {1'b0, r_mcand};
        w_y   = r_lo[0] ? w_ext : '0;
`ifdef SEQ_MULT_SIGNED_EN
        // The multiplier's MSB carries weight -2^(W-1) in two's complement,
        // so its partial product is subtracted on the last iteration.
        w_sub  = r_sgn & w_last;
        w_fill = r_sgn & w_sum[W];
`else
        w_sub  = 1'b0;
        w_fill = 1'b0;
`endif
        // {hi,lo} >> 1 with the selected fill bit entering at the top.
        w_hi_nx = {w_fill, w_sum[W:1]};
        w_lo_nx = {w_sum[0], r_lo[W-1:1]};
    end

    seq_mult_addsub #(
        .W (W)
    ) u_addsub (
        .x   (r_hi),
        .y   (w_y),
        .sub (w_sub),
        .s   (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_sgn   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            p       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_mcand <= a;
                        r_hi    <= '0;
                        r_lo    <= b;
                        r_cnt   <= c_cnt_w'(W - 1);
                        r_sgn   <= w_sgn_in;
                        p       <= '0;
                        busy    <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt - 1'b1;
                    if (w_last) begin
                        p       <= {w_hi_nx[W-1:0], w_lo_nx};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : seq_mult
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_mult
//  Purpose  : Self-checking bench for seq_mult. A W=4 instance runs directed
//             vectors (reset, latency, ignored start, mid-op reset,
//             back-to-back); a W=8 instance runs 1000 operand pairs against
//             a reference product. Signed vectors are built when
//             SEQ_MULT_SIGNED_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult;

    localparam int W4 = 4;
    localparam int W8 = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    a = '0;
    logic [3:0]    b = '0;
    logic          sm = 1'b0;
    logic          busy;
    logic          done;
    logic [7:0]    p;

    logic          start8 = 1'b0;
    logic [7:0]    a8 = '0;
    logic [7:0]    b8 = '0;
    logic          sm8 = 1'b0;
    logic          busy8;
    logic          done8;
    logic [15:0]   p8;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_mult #(.W(W4)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode (sm),
`endif
        .busy        (busy),
        .done        (done),
        .p           (p)
    );

    seq_mult #(.W(W8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .a           (a8),
        .b           (b8),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode (sm8),
`endif
        .busy        (busy8),
        .done        (done8),
        .p           (p8)
    );

    // Issue one operation on the W=4 instance and observe it for W+4 cycles.
    // lat is the negedge index (1 = first cycle after acceptance) of done.
    task automatic run4(input logic [3:0] ia, input logic [3:0] ib, input logic isg,
                        output logic [7:0] prod, output int nbusy, output int lat,
                        output int ndone);
        @(negedge clk);
        a = ia; b = ib; sm = isg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0; lat = 0; ndone = 0; prod = 8'hxx;
        for (int i = 1; i <= W4 + 4; i++) begin
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = i;
                    prod = p;
                end
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                         input logic s);
        logic signed [15:0] sx;
        logic signed [15:0] sy;
        if (s) begin
            sx = {{8{x[7]}}, x};
            sy = {{8{y[7]}}, y};
            return 16'(sx * sy);
        end
        return 16'({8'd0, x} * {8'd0, y});
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++;
        if (p !== 8'h00) begin miscompares++; $display("FAIL reset_p got %h want 00", p); end
        vectors++;
        if (p8 !== 16'h0000 || busy8 !== 1'b0) begin
            miscompares++; $display("FAIL reset_dut8 got p8=%h busy8=%b want 0000/0", p8, busy8);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] pr; int nb; int lat; int nd;
        run4(4'd2, 4'd4, 1'b0, pr, nb, lat, nd);
        vectors++;
        if (pr !== 8'h08) begin miscompares++; $display("FAIL basic_p got %h want 08", pr); end
        vectors++;
        if (nb != W4) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want %0d", nb, W4); end
        vectors++;
        if (lat != W4 + 1) begin miscompares++; $display("FAIL basic_latency got %0d want %0d", lat, W4 + 1); end
        vectors++;
        if (nd != 1) begin miscompares++; $display("FAIL basic_done_pulses got %0d want 1", nd); end
        vectors++;
        if (p !== 8'h08) begin miscompares++; $display("FAIL basic_p_held got %h want 08", p); end
    endtask

    task automatic test_unsigned();
        logic [3:0] va [3] = '{4'd15, 4'd15, 4'd0};
        logic [3:0] vb [3] = '{4'd3, 4'd15, 4'd9};
        logic [7:0] ve [3] = '{8'h2D, 8'hE1, 8'h00};
        logic [7:0] pr; int nb; int lat; int nd;
        for (int i = 0; i < 3; i++) begin
            run4(va[i], vb[i], 1'b0, pr, nb, lat, nd);
            vectors++;
            if (pr !== ve[i] || nd != 1) begin
                miscompares++;
                $display("FAIL unsigned_%0d got p=%h dones=%0d want p=%h dones=1", i, pr, nd, ve[i]);
            end
        end
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed();
        logic [3:0] va [4] = '{4'hF, 4'h8, 4'h7, 4'hF};
        logic [3:0] vb [4] = '{4'h3, 4'h8, 4'h8, 4'hF};
        logic       vs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] ve [4] = '{8'hFD, 8'h40, 8'hC8, 8'hE1};
        logic [7:0] pr; int nb; int lat; int nd;
        for (int i = 0; i < 4; i++) begin
            run4(va[i], vb[i], vs[i], pr, nb, lat, nd);
            vectors++;
            if (pr !== ve[i] || nd != 1) begin
                miscompares++;
                $display("FAIL signed_%0d got p=%h dones=%0d want p=%h dones=1", i, pr, nd, ve[i]);
            end
        end
    endtask
`endif

    task automatic test_ignore_start();
        int nd; logic [7:0] pr; int both;
        nd = 0; pr = 8'hxx; both = 0;
        @(negedge clk);
        a = 4'd3; b = 4'd5; sm = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= W4 + 4; i++) begin
            // Foreign request while busy: must be ignored.
            if (i == 2) begin a = 4'd15; b = 4'd15; start = 1'b1; end
            if (i == 3) start = 1'b0;
            if (busy && done) both++;
            if (done) begin nd++; pr = p; end
            @(negedge clk);
        end
        vectors++;
        if (pr !== 8'h0F) begin miscompares++; $display("FAIL ignore_start_p got %h want 0f", pr); end
        vectors++;
        if (nd != 1) begin miscompares++; $display("FAIL ignore_start_dones got %0d want 1", nd); end
        vectors++;
        if (both != 0) begin miscompares++; $display("FAIL busy_done_overlap got %0d want 0", both); end
    endtask

    task automatic test_reset_mid();
        int nd; logic [7:0] pr; int nb; int lat; int nd2;
        nd = 0;
        @(negedge clk);
        a = 4'd5; b = 4'd5; sm = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_outputs got busy=%b done=%b p=%h want 0/0/00", busy, done, p);
        end
        for (int i = 0; i < W4 + 4; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        vectors++;
        if (nd != 0) begin miscompares++; $display("FAIL reset_mid_stray_done got %0d want 0", nd); end
        run4(4'd6, 4'd7, 1'b0, pr, nb, lat, nd2);
        vectors++;
        if (pr !== 8'h2A || nd2 != 1) begin
            miscompares++; $display("FAIL reset_mid_after got p=%h dones=%0d want p=2a dones=1", pr, nd2);
        end
    endtask

    task automatic test_back_to_back();
        int dc [3]; int n; logic [7:0] pv [3];
        n = 0;
        @(negedge clk);
        a = 4'd3; b = 4'd3; sm = 1'b0; start = 1'b1;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk);
            if (done) begin dc[n] = cyc; pv[n] = p; n++; end
        end
        start = 1'b0;
        repeat (W4 + 4) @(negedge clk);
        vectors++;
        if (n != 3) begin
            miscompares++; $display("FAIL b2b_done_count got %0d want 3", n);
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (pv[k] !== 8'h09) begin miscompares++; $display("FAIL b2b_p_%0d got %h want 09", k, pv[k]); end
            end
            for (int k = 1; k < 3; k++) begin
                vectors++;
                if (dc[k] - dc[k-1] != W4 + 2) begin
                    miscompares++;
                    $display("FAIL b2b_spacing_%0d got %0d want %0d", k, dc[k] - dc[k-1], W4 + 2);
                end
            end
        end
    endtask

    task automatic test_random8();
        logic [7:0] ca; logic [7:0] cb; logic csg; logic [15:0] exp_p;
        int last_done; int waited;
        @(negedge clk);
        ca = 8'($urandom); cb = 8'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
        csg = 1'($urandom);
`else
        csg = 1'b0;
`endif
        exp_p = ref8(ca, cb, csg);
        a8 = ca; b8 = cb; sm8 = csg; start8 = 1'b1;
        last_done = -1;
        for (int n = 0; n < 1000; n++) begin
            waited = 0;
            do begin @(negedge clk); waited++; end while (!done8 && waited < 3 * W8);
            vectors++;
            if (!done8) begin
                miscompares++; $display("FAIL rand8_timeout op %0d got no done want done", n);
                break;
            end
            if (p8 !== exp_p) begin
                miscompares++;
                $display("FAIL rand8_p op %0d a=%h b=%h s=%b got %h want %h", n, ca, cb, csg, p8, exp_p);
            end
            if (last_done >= 0) begin
                vectors++;
                if (cyc - last_done != W8 + 2) begin
                    miscompares++;
                    $display("FAIL rand8_spacing op %0d got %0d want %0d", n, cyc - last_done, W8 + 2);
                end
            end
            last_done = cyc;
            ca = 8'($urandom); cb = 8'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
            csg = 1'($urandom);
`endif
            exp_p = ref8(ca, cb, csg);
            a8 = ca; b8 = cb; sm8 = csg;
        end
        start8 = 1'b0;
        repeat (W8 + 4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unsigned();
`ifdef SEQ_MULT_SIGNED_EN
        test_signed();
`endif
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_seq_mult
`default_nettype wire
